// File: rtl/clks_alot_event_pcap_if.sv
// Packet capture stream: 32-bit words with valid/ready handshake, last marker and
// the byte count of the final word.
interface clks_alot_event_pcap_if;
    logic        valid;
    logic        ready;
    logic        last;
    logic [31:0] data;
    logic [1:0]  length_lower;

    modport master (output valid, last, data, length_lower, input ready);
    modport slave  (input valid, last, data, length_lower, output ready);
endinterface

// File: rtl/clks_alot_event_pcap.sv
// Captures rising violation flags with timestamp and sequence number into a record FIFO,
// then streams each record as a 3-word packet (header, timestamp, drops/state).
module clks_alot_event_pcap #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned STATE_W = 16,
    parameter logic [7:0]  MAGIC   = 8'hCA
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic                        enable_i,
    input  logic [10:0]                 violations_i,
    input  logic [STATE_W-1:0]          recovered_clk_state_i,
    clks_alot_event_pcap_if.master      pcap,
    output logic [7:0]                  overflow_count_o,
    output logic                        error_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StHdr, StTs, StSt} state_e;
    state_e state_q, state_d;

    logic [31:0]        ts_q;
    logic [7:0]         seq_q;
    logic [7:0]         pend_q;
    logic [10:0]        prev_q;
    logic [AW:0]        wr_ptr_q, rd_ptr_q;

    logic [10:0]        mask_mem  [DEPTH];
    logic [31:0]        ts_mem    [DEPTH];
    logic [STATE_W-1:0] st_mem    [DEPTH];
    logic [7:0]         drops_mem [DEPTH];
    logic [7:0]         seq_mem   [DEPTH];

    logic [10:0]        hold_mask_q;
    logic [31:0]        hold_ts_q;
    logic [STATE_W-1:0] hold_st_q;
    logic [7:0]         hold_drops_q;
    logic [7:0]         hold_seq_q;

    logic [10:0] new_mask;
    logic        empty, full, capture, pop, push, drop, xfer;

    assign new_mask = violations_i & ~prev_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign capture  = clk_en && enable_i && (|new_mask);
    // A full FIFO still accepts when the serialiser pops in the same cycle.
    assign push     = capture && (!full || pop);
    assign drop     = capture && !push;
    assign xfer     = clk_en && pcap.valid && pcap.ready;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clk_en && !empty) begin
                    pop     = 1'b1;
                    state_d = StHdr;
                end
            end
            StHdr: if (xfer) state_d = StTs;
            StTs:  if (xfer) state_d = StSt;
            StSt: begin
                if (xfer) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StHdr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            ts_q             <= '0;
            seq_q            <= '0;
            pend_q           <= '0;
            prev_q           <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            overflow_count_o <= '0;
            error_o          <= 1'b0;
            hold_mask_q      <= '0;
            hold_ts_q        <= '0;
            hold_st_q        <= '0;
            hold_drops_q     <= '0;
            hold_seq_q       <= '0;
        end else begin
            state_q <= state_d;
            if (clk_en) begin
                ts_q   <= ts_q + 32'd1;
                prev_q <= violations_i;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
                seq_q    <= seq_q + 8'd1;
                pend_q   <= '0;
            end
            if (drop) begin
                if (pend_q != 8'hFF) pend_q <= pend_q + 8'd1;
                if (overflow_count_o != 8'hFF) overflow_count_o <= overflow_count_o + 8'd1;
                error_o <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + PtrOne;
                hold_mask_q  <= mask_mem[rd_ptr_q[AW-1:0]];
                hold_ts_q    <= ts_mem[rd_ptr_q[AW-1:0]];
                hold_st_q    <= st_mem[rd_ptr_q[AW-1:0]];
                hold_drops_q <= drops_mem[rd_ptr_q[AW-1:0]];
                hold_seq_q   <= seq_mem[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr_q[AW-1:0]]  <= new_mask;
            ts_mem[wr_ptr_q[AW-1:0]]    <= ts_q;
            st_mem[wr_ptr_q[AW-1:0]]    <= recovered_clk_state_i;
            drops_mem[wr_ptr_q[AW-1:0]] <= pend_q;
            seq_mem[wr_ptr_q[AW-1:0]]   <= seq_q;
        end
    end

    assign pcap.valid        = (state_q != StIdle);
    assign pcap.last         = (state_q == StSt);
    assign pcap.length_lower = 2'b00;

    always_comb begin
        pcap.data = '0;
        unique case (state_q)
            StHdr:   pcap.data = {MAGIC, hold_seq_q, 5'b0, hold_mask_q};
            StTs:    pcap.data = hold_ts_q;
            StSt:    pcap.data = {hold_drops_q, 24'(hold_st_q)};
            default: pcap.data = '0;
        endcase
    end
endmodule

// File: tb/tb_clks_alot_event_pcap.sv
// Bench for clks_alot_event_pcap: directed scenarios plus randomized traffic checked
// against a queue-based record/packet model.
module tb_clks_alot_event_pcap;
    localparam int DEPTH = 4;

    logic        clk, rst_n, clk_en, enable;
    logic [10:0] viol;
    logic [15:0] st;
    logic [7:0]  ovf;
    logic        err;
    int          n_cmp = 0;
    int          n_bad = 0;

    clks_alot_event_pcap_if bus();

    clks_alot_event_pcap #(.DEPTH(DEPTH), .STATE_W(16), .MAGIC(8'hCA)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .clk_en                (clk_en),
        .enable_i              (enable),
        .violations_i          (viol),
        .recovered_clk_state_i (st),
        .pcap                  (bus),
        .overflow_count_o      (ovf),
        .error_o               (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: records live in a queue; the packet in flight is a record plus
    // a word index.
    typedef struct packed {
        bit [10:0] mask;
        bit [31:0] ts;
        bit [15:0] st;
        bit [7:0]  drops;
        bit [7:0]  seq;
    } rec_t;

    rec_t      mq[$];
    rec_t      m_cur;
    bit        m_busy;
    int        m_widx;
    bit [31:0] m_ts;
    bit [7:0]  m_seq, m_pend, m_ovf;
    bit        m_err;
    bit [10:0] m_prev;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_busy = 0; m_widx = 0; m_ts = 0; m_seq = 0;
            m_pend = 0; m_ovf = 0; m_err = 0; m_prev = 0;
        end else if (clk_en) begin
            bit        mpop, macc;
            bit [10:0] nm;
            rec_t      r;
            mpop = 0;
            macc = 0;
            if (!m_busy) mpop = (mq.size() > 0);
            else if (bus.ready) begin
                if (m_widx == 2) begin
                    mpop = (mq.size() > 0);
                    if (!mpop) m_busy = 0;
                end else m_widx++;
            end
            nm = viol & ~m_prev;
            if (enable && nm != 0) begin
                if (mq.size() < DEPTH || mpop) begin
                    r = '{nm, m_ts, st, m_pend, m_seq};
                    macc = 1;
                    m_seq++;
                    m_pend = 0;
                end else begin
                    if (m_pend != 8'hFF) m_pend++;
                    if (m_ovf != 8'hFF) m_ovf++;
                    m_err = 1;
                end
            end
            if (mpop) begin
                m_cur  = mq.pop_front();
                m_busy = 1;
                m_widx = 0;
            end
            if (macc) mq.push_back(r);
            m_prev = viol;
            m_ts++;
        end
    end

    function automatic logic [31:0] m_word();
        case (m_widx)
            0:       return {8'hCA, m_cur.seq, 5'b0, m_cur.mask};
            1:       return m_cur.ts;
            default: return {m_cur.drops, 8'h00, m_cur.st};
        endcase
    endfunction

    function automatic logic [44:0] exp_vec();
        return {m_busy, m_busy && (m_widx == 2), 2'b00, m_busy ? m_word() : 32'h0, m_ovf, m_err};
    endfunction

    function automatic logic [44:0] act_vec();
        return {bus.valid, bus.last, bus.length_lower, bus.valid ? bus.data : 32'h0, ovf, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; enable = 1'b1; viol = '0; st = '0; bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.valid, bus.last, bus.length_lower} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {bus.valid, bus.last, bus.length_lower});
        end
        n_cmp++;
        if (bus.data !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 00000000", bus.data);
        end
        n_cmp++;
        if ({ovf, err} !== 9'h0) begin
            n_bad++; $display("FAIL reset_counters: got ovf=%0d err=%b want 0/0", ovf, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] exp_w [3] = '{32'hCA000004, 32'h00000040, 32'h00001234};
        st = 16'h1234;
        repeat (64) @(posedge clk);
        #1 viol = 11'h004;
        step();
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_bad++; $display("FAIL latency_store_cycle: valid got %b want 0", bus.valid);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus.valid, bus.last, bus.length_lower, bus.data} !== {1'b1, i == 2, 2'b00, exp_w[i]}) begin
                n_bad++;
                $display("FAIL basic_word%0d: got v=%b l=%b ll=%0d d=%h want v=1 l=%b ll=0 d=%h",
                         i, bus.valid, bus.last, bus.length_lower, bus.data, i == 2, exp_w[i]);
            end
            step();
        end
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_end: valid got %b want 0", bus.valid);
        end
    endtask

    task automatic test_held_flag();
        int vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.valid) vcnt++;
        end
        n_cmp++;
        if (vcnt !== 0) begin
            n_bad++; $display("FAIL held_flag: valid cycles got %0d want 0", vcnt);
        end
        viol = 11'h205;
        step();
        step();
        n_cmp++;
        if ({bus.valid, bus.data} !== {1'b1, 32'hCA010201}) begin
            n_bad++; $display("FAIL two_bits_hdr: got v=%b d=%h want v=1 d=ca010201", bus.valid, bus.data);
        end
        repeat (3) step();
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_bad++; $display("FAIL two_bits_end: valid got %b want 0", bus.valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w [15];
        int          n = 0;
        logic [31:0] eh;
        bus.ready = 1'b0; viol = '0;
        step();
        viol = 11'h001;
        step();
        step();
        for (int k = 1; k <= 6; k++) begin
            viol = 11'(1 << k);
            step();
        end
        n_cmp++;
        if ({ovf, err} !== {8'd2, 1'b1}) begin
            n_bad++; $display("FAIL overflow_count: got ovf=%0d err=%b want 2/1", ovf, err);
        end
        n_cmp++;
        if ({bus.valid, bus.data} !== {1'b1, 32'hCA020001}) begin
            n_bad++; $display("FAIL stalled_hdr: got v=%b d=%h want v=1 d=ca020001", bus.valid, bus.data);
        end
        bus.ready = 1'b1;
        step();
        step();
        viol = 11'h080;
        step();
        n_cmp++;
        if (ovf !== 8'd2) begin
            n_bad++; $display("FAIL pop_push_same_cycle: ovf got %0d want 2", ovf);
        end
        for (int c = 0; c < 40 && n < 15; c++) begin
            if (bus.valid) begin
                w[n] = bus.data;
                n++;
            end
            step();
        end
        n_cmp++;
        if (n !== 15) begin
            n_bad++; $display("FAIL drain_words: got %0d want 15", n);
        end
        for (int p = 0; p < 5; p++) begin
            eh = {8'hCA, 8'(3 + p), 5'b0, (p < 4) ? 11'(1 << (p + 1)) : 11'h080};
            n_cmp++;
            if (w[3*p] !== eh) begin
                n_bad++; $display("FAIL drain_hdr%0d: got %h want %h", p, w[3*p], eh);
            end
            n_cmp++;
            if (w[3*p+2][31:24] !== ((p == 4) ? 8'd2 : 8'd0)) begin
                n_bad++; $display("FAIL drain_drops%0d: got %0d want %0d", p, w[3*p+2][31:24], (p == 4) ? 2 : 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  hdrs = 0;
        int  budget = 0;
        int  last_seq = -1;
        bit  wrapped = 0;
        while (hdrs < 300 && budget < 6000) begin
            bus.ready = budget[0];
            if (budget % 4 == 0) viol = '0;
            else if (budget % 4 == 1) viol = 11'(1 << ((budget / 4) % 11));
            if (m_busy && m_widx == 0 && bus.ready) begin
                if (last_seq == 255 && bus.data[23:16] == 8'h00) wrapped = 1;
                last_seq = int'(bus.data[23:16]);
                hdrs++;
            end
            step();
            budget++;
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL b2b_cycle%0d: got %h want %h", budget, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (hdrs < 300) begin
            n_bad++; $display("FAIL b2b_budget: headers got %0d want 300", hdrs);
        end
        n_cmp++;
        if (wrapped !== 1'b1) begin
            n_bad++; $display("FAIL seq_wrap: wrap seen %b want 1", wrapped);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            clk_en = ($urandom_range(0, 9) != 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) viol = 11'($urandom);
            st = 16'($urandom);
            bus.ready = 1'($urandom_range(0, 1));
            step();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL random_cycle%0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        clk_en = 1'b1; enable = 1'b1; bus.ready = 1'b1;
        while (!(m_busy && m_widx == 1) && c < 100) begin
            viol = (c % 2 == 1) ? 11'h010 : 11'h000;
            step();
            c++;
        end
        n_cmp++;
        if ({bus.valid, bus.last, m_busy, m_widx == 1} !== 4'b1011) begin
            n_bad++; $display("FAIL reach_ts: got v=%b l=%b want v=1 l=0 in timestamp word", bus.valid, bus.last);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.valid, bus.last, ovf, err} !== 11'h0) begin
            n_bad++; $display("FAIL reset_mid: got v=%b l=%b ovf=%0d err=%b want all 0", bus.valid, bus.last, ovf, err);
        end
        viol = '0;
        step();
        rst_n = 1'b1;
        viol = 11'h008;
        step();
        step();
        n_cmp++;
        if ({bus.valid, bus.data[31:16], bus.data[10:0]} !== {1'b1, 16'hCA00, 11'h008}) begin
            n_bad++; $display("FAIL post_reset_hdr: got v=%b d=%h want v=1 d=ca000008", bus.valid, bus.data);
        end
        repeat (4) begin
            step();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL post_reset_model: got %h want %h", act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_held_flag();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clks_alot_event_pcap.md
Name: clks_alot_event_pcap

Overview:
- Downstream consumer of the clock-recovery top: watches its violation flags and recovered clock state.
- Captures each new violation event with a timestamp and sequence number into a small record FIFO.
- Serialises each record as a 3-word packet on the 32-bit pcap stream (valid/ready/last/length_lower) toward the capture sink.

Parameters:
- DEPTH, 4, record FIFO depth in records; power of 2, >= 2.
- STATE_W, 16, width of packed recovered clock state; 1..24.
- MAGIC, 8'hCA, header tag byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  clock enable; all state advances only when high
- enable_i  in  1  capture enable
- violations_i  in  11  {bandpass hi/lo over/under (4), drift hi/lo pos/neg (4), excessive drift, expected mismatch, preemptive mismatch}, bit 0 = high_rate_bandpass_overshoot
- recovered_clk_state_i  in  STATE_W  packed recovered clock state
- pcap_ready_i  in  1  sink ready
- pcap_valid_o  out  1  word valid
- pcap_last_o  out  1  last word of packet
- pcap_data_o  out  32  packet word
- pcap_length_lower_o  out  2  valid bytes in last word mod 4; always 0 (all 4 valid)
- overflow_count_o  out  8  total dropped records, saturating
- error_o  out  1  sticky, set on any drop

Behaviour:
- Reset (async assert, sync release): timestamp, seq, FIFO pointers, prev-flag register, pending-drop and overflow counters = 0; FSM = IDLE; all outputs 0.
- Timestamp: 32-bit, +1 each clk_en cycle, wraps 0xFFFFFFFF -> 0.
- Edge detect: prev <= violations_i each clk_en cycle, regardless of enable_i. new_mask = violations_i & ~prev. Held flags produce no further events.
- Capture: when clk_en & enable_i & |new_mask, form a record {new_mask, timestamp (current value), recovered_clk_state_i, pending_drops}.
- Push: accepted if FIFO not full, or full and a record is popped the same cycle.
  - Accepted: seq stamped, then seq +1 (wraps 255 -> 0); pending_drops cleared.
  - Rejected: pending_drops +1 and overflow_count_o +1, both saturating at 255; error_o <= 1.
- Packet format:
  - word0 = {MAGIC[7:0], seq[7:0], 5'b0, new_mask[10:0]}
  - word1 = timestamp
  - word2 = {pending_drops[7:0], zero pad, state[STATE_W-1:0]}
- FSM:
  - IDLE -> HDR when FIFO non-empty; record is popped into the output holding register on that transition.
  - HDR -> TS -> ST, each advancing on clk_en & pcap_valid_o & pcap_ready_i.
  - ST -> HDR on transfer if FIFO non-empty (next record popped, no bubble); otherwise ST -> IDLE.
  - pcap_valid_o = 1 in HDR/TS/ST. pcap_last_o = 1 only in ST.
- Handshake: data/last/valid held stable until a transfer; valid never drops without a transfer. With clk_en = 0, no transfer occurs even if ready is high.
- Latency: an event sampled in cycle N (FIFO empty, FSM IDLE) gives word0 valid in cycle N+2 (store at N, pop at N+1).
- Enable_i low mid-packet: the current and queued packets still drain; only new captures are blocked.
- Reset mid-packet: packet abandoned, valid drops immediately; no partial resume.

Test Plan:
- Violation bit 2 rises at timestamp 0x40, state = 0x1234, ready = 1 -> 3 words 0xCA000004, 0x00000040, 0x00001234; last only on word 3; length_lower = 0; seq next = 1.
- Hold bit 2 high for 20 cycles -> exactly one packet. Bits 0 and 9 rise together -> one packet with mask 0x201.
- ready = 0, DEPTH = 4, 6 distinct events -> 4 stored, overflow_count_o = 2, error_o = 1. After release, the 4th record's word2[31:24] = 0. The next accepted record carries drops = 2.
- Full FIFO with pop and capture in the same cycle -> push accepted, no drop counted.
- ready toggling 1/0 each cycle -> every word is held stable while stalled; back-to-back packets have no IDLE bubble; seq wraps 255 -> 0 after 256 packets.
- rst_n asserted mid-TS word -> valid 0 immediately, all counters 0; post-reset first packet has seq 0.
